gpio_bank_ctrl: RTL and testbench

Parametrised management-side GPIO bank controller for the user-project I/O ring. It generalises the fixed 16-bit checkbit handshake to WIDTH pins and adds:
- per-pin direction control
- input synchronisation and programmable debounce
- edge-selectable interrupts with W1C status

Firmware accesses it through a single-cycle register port. Pad-side signals connect to the mprj_io pad controls.

---
 rtl/gpio_bank_pkg.sv | 17 +
 rtl/gpio_bank_ctrl_if.sv | 20 ++
 rtl/gpio_pin_filter.sv | 56 +++++
 rtl/gpio_bank_ctrl.sv | 101 ++++++++++
 tb/tb_gpio_bank_ctrl.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/gpio_bank_pkg.sv
// Shared constants for the GPIO bank controller: register addresses and
// reset values of the registers that do not reset to zero.
package gpio_bank_pkg;

  localparam logic [2:0] ADDR_DATA_OUT   = 3'd0;
  localparam logic [2:0] ADDR_OEB        = 3'd1;
  localparam logic [2:0] ADDR_DATA_IN    = 3'd2;
  localparam logic [2:0] ADDR_IRQ_EN     = 3'd3;
  localparam logic [2:0] ADDR_IRQ_EDGE   = 3'd4;
  localparam logic [2:0] ADDR_IRQ_STATUS = 3'd5;
  localparam logic [2:0] ADDR_DEBOUNCE   = 3'd6;

  // Widest bank is 32 pins; the top truncates these to WIDTH.
  localparam logic [31:0] OEB_RST      = 32'hFFFF_FFFF;
  localparam logic [31:0] IRQ_EDGE_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/gpio_bank_ctrl_if.sv
// Single-cycle firmware register port of the GPIO bank controller.
interface gpio_bank_ctrl_if #(
  parameter int WIDTH = 16
);
  logic [2:0]       reg_addr;
  logic             reg_we;
  logic             reg_re;
  logic [WIDTH-1:0] reg_wdata;
  logic [WIDTH-1:0] reg_rdata;

  modport master (
    output reg_addr, reg_we, reg_re, reg_wdata,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr, reg_we, reg_re, reg_wdata,
    output reg_rdata
  );
endinterface

// File: rtl/gpio_pin_filter.sv
// One pad input: synchroniser, debounce counter and the committed value d,
// with one-cycle rise/fall pulses aligned to the edge where d changes.
module gpio_pin_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pin,
  input  logic [DEBOUNCE_W-1:0] threshold,
  output logic                  d,
  output logic                  rise,
  output logic                  fall
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s;
  logic [DEBOUNCE_W-1:0]  cnt;
  logic [DEBOUNCE_W-1:0]  cnt_next;
  logic                   d_next;

  assign s = sync_p0[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
      cnt     <= '0;
      d       <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], pin};
      cnt     <= cnt_next;
      d       <= d_next;
    end
  end

  // >= rather than == so a threshold lowered mid-count commits on the next mismatch
  always_comb begin
    d_next   = d;
    cnt_next = cnt;
    if (threshold == '0) begin
      d_next   = s;
      cnt_next = '0;
    end else if (s == d) begin
      cnt_next = '0;
    end else if (cnt >= threshold - DEBOUNCE_W'(1)) begin
      d_next   = s;
      cnt_next = '0;
    end else begin
      cnt_next = cnt + DEBOUNCE_W'(1);
    end
  end

  assign rise = ~d & d_next;
  assign fall = d & ~d_next;

endmodule

// File: rtl/gpio_bank_ctrl.sv
// Management-side GPIO bank: direction/data registers, filtered inputs and
// edge interrupts with write-1-to-clear status, behind a register port.
module gpio_bank_ctrl
  import gpio_bank_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_W  = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  gpio_bank_ctrl_if.slave  bus,
  input  logic [WIDTH-1:0] pad_in,
  output logic [WIDTH-1:0] pad_out,
  output logic [WIDTH-1:0] pad_oeb,
  output logic             irq
);

  logic [WIDTH-1:0]      data_out;
  logic [WIDTH-1:0]      oeb;
  logic [WIDTH-1:0]      irq_en;
  logic [WIDTH-1:0]      irq_edge;
  logic [WIDTH-1:0]      irq_status;
  logic [WIDTH-1:0]      status_next;
  logic [DEBOUNCE_W-1:0] debounce;
  logic [WIDTH-1:0]      data_in;
  logic [WIDTH-1:0]      rise;
  logic [WIDTH-1:0]      fall;
  logic [WIDTH-1:0]      event_hit;
  logic [WIDTH-1:0]      w1c;
  logic [WIDTH-1:0]      rd_mux;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_pin_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_W  (DEBOUNCE_W)
    ) u_filter (
      .clk       (wb_clk_i),
      .rst       (wb_rst_i),
      .pin       (pad_in[i]),
      .threshold (debounce),
      .d         (data_in[i]),
      .rise      (rise[i]),
      .fall      (fall[i])
    );
  end

  assign event_hit = (rise & irq_edge) | (fall & ~irq_edge);

  // A new event in the same cycle as its W1C keeps the bit set
  always_comb begin
    w1c = '0;
    if (bus.reg_we && bus.reg_addr == ADDR_IRQ_STATUS) w1c = bus.reg_wdata;
    status_next = (irq_status & ~w1c) | event_hit;
  end

  always_comb begin
    rd_mux = '0;
    case (bus.reg_addr)
      ADDR_DATA_OUT:   rd_mux = data_out;
      ADDR_OEB:        rd_mux = oeb;
      ADDR_DATA_IN:    rd_mux = data_in;
      ADDR_IRQ_EN:     rd_mux = irq_en;
      ADDR_IRQ_EDGE:   rd_mux = irq_edge;
      ADDR_IRQ_STATUS: rd_mux = irq_status;
      ADDR_DEBOUNCE:   rd_mux = WIDTH'(debounce);
      default:         rd_mux = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      data_out      <= '0;
      oeb           <= WIDTH'(OEB_RST);
      irq_en        <= '0;
      irq_edge      <= WIDTH'(IRQ_EDGE_RST);
      irq_status    <= '0;
      debounce      <= '0;
      bus.reg_rdata <= '0;
      irq           <= 1'b0;
    end else begin
      if (bus.reg_we) begin
        case (bus.reg_addr)
          ADDR_DATA_OUT: data_out <= bus.reg_wdata;
          ADDR_OEB:      oeb      <= bus.reg_wdata;
          ADDR_IRQ_EN:   irq_en   <= bus.reg_wdata;
          ADDR_IRQ_EDGE: irq_edge <= bus.reg_wdata;
          ADDR_DEBOUNCE: debounce <= DEBOUNCE_W'(bus.reg_wdata);
          default: ;
        endcase
      end
      irq_status <= status_next;
      if (bus.reg_re) bus.reg_rdata <= rd_mux;
      irq <= |(irq_status & irq_en);
    end
  end

  assign pad_out = data_out;
  assign pad_oeb = oeb;

endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// Directed-vector bench for gpio_bank_ctrl with hand-computed expectations.
module tb_gpio_bank_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pad_in = '0;
  logic [15:0] pad_out;
  logic [15:0] pad_oeb;
  logic        irq;
  logic [15:0] rv;
  logic        any_high;
  int          nvec = 0;
  int          nerr = 0;

  gpio_bank_ctrl_if #(.WIDTH(16)) bus ();

  gpio_bank_ctrl #(
    .WIDTH       (16),
    .SYNC_STAGES (2),
    .DEBOUNCE_W  (8)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus),
    .pad_in   (pad_in),
    .pad_out  (pad_out),
    .pad_oeb  (pad_oeb),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus.reg_addr  = a;
    bus.reg_wdata = d;
    bus.reg_we    = 1'b1;
    tick();
    bus.reg_we    = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    bus.reg_addr = a;
    bus.reg_re   = 1'b1;
    tick();
    bus.reg_re   = 1'b0;
    d = bus.reg_rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.reg_addr = '0; bus.reg_we = 1'b0; bus.reg_re = 1'b0; bus.reg_wdata = '0;

    // Reset with pads toggling
    for (int k = 0; k < 4; k++) begin
      pad_in = 16'($urandom);
      tick();
    end
    pad_in = '0;
    tick();
    check("rst_oeb", pad_oeb, 32'hFFFF);
    check("rst_out", pad_out, 32'h0);
    check("rst_irq", irq, 32'h0);
    check("rst_rdata", bus.reg_rdata, 32'h0);
    rst = 1'b0;
    rd(3'd1, rv); check("rd_oeb_rst", rv, 32'hFFFF);
    rd(3'd4, rv); check("rd_edge_rst", rv, 32'hFFFF);
    rd(3'd5, rv); check("rd_status_rst", rv, 32'h0);
    rd(3'd6, rv); check("rd_dbc_rst", rv, 32'h0);
    wr(3'd7, 16'h5A5A);
    rd(3'd7, rv); check("rd_addr7", rv, 32'h0);

    // Output path
    wr(3'd1, 16'h00FF); check("oeb_pad", pad_oeb, 32'h00FF);
    wr(3'd0, 16'hA000); check("out_pad", pad_out, 32'hA000);
    check("out_hi", pad_out[15:8], 32'hA0);
    rd(3'd0, rv); check("rd_data_out", rv, 32'hA000);

    // Input path, no debounce: d changes on the 3rd edge, read sees it on the 4th
    bus.reg_addr = 3'd2; bus.reg_re = 1'b1;
    pad_in = 16'h00F0;
    tick(3); check("din_f0_early", bus.reg_rdata[7:0], 32'h00);
    tick();  check("din_f0", bus.reg_rdata[7:0], 32'hF0);
    pad_in = 16'h000F;
    tick(3); check("din_0f_early", bus.reg_rdata[7:0], 32'hF0);
    tick();  check("din_0f", bus.reg_rdata[7:0], 32'h0F);
    bus.reg_re = 1'b0;

    // Debounce of 4: a 3-cycle glitch is filtered, a held level lands after 6
    pad_in = '0;
    tick(4);
    wr(3'd6, 16'h0004);
    rd(3'd6, rv); check("rd_dbc", rv, 32'h4);
    bus.reg_addr = 3'd2; bus.reg_re = 1'b1;
    any_high = 1'b0;
    pad_in = 16'h0001;
    for (int k = 0; k < 3; k++) begin tick(); any_high |= bus.reg_rdata[0]; end
    pad_in = '0;
    for (int k = 0; k < 5; k++) begin tick(); any_high |= bus.reg_rdata[0]; end
    check("glitch_filtered", any_high, 32'h0);
    pad_in = 16'h0001;
    tick(6); check("dbc_hold_early", bus.reg_rdata[0], 32'h0);
    tick();  check("dbc_hold", bus.reg_rdata[0], 32'h1);
    bus.reg_re = 1'b0;

    // Interrupts
    wr(3'd5, 16'hFFFF);
    rd(3'd5, rv); check("status_cleared", rv, 32'h0);
    wr(3'd6, 16'h0000);
    wr(3'd3, 16'h0003);
    wr(3'd4, 16'hFFFE);
    pad_in = 16'h0002;
    tick(3); check("irq_before", irq, 32'h0);
    tick();  check("irq_set", irq, 32'h1);
    rd(3'd5, rv); check("status_both", rv, 32'h0003);
    wr(3'd5, 16'h0001);
    rd(3'd5, rv); check("status_w1c0", rv, 32'h0002);
    check("irq_hold", irq, 32'h1);
    wr(3'd5, 16'h0002);
    rd(3'd5, rv); check("status_w1c1", rv, 32'h0);
    check("irq_clear", irq, 32'h0);

    // Set wins over a W1C landing on the same edge as a new event
    pad_in = 16'h0000; tick(4);
    pad_in = 16'h0002; tick(4);
    pad_in = 16'h0000; tick(4);
    rd(3'd5, rv); check("status_pre_race", rv, 32'h0002);
    pad_in = 16'h0002;
    tick(2);
    wr(3'd5, 16'h0002);
    rd(3'd5, rv); check("set_wins", rv[1], 32'h1);
    wr(3'd5, 16'h0002);
    rd(3'd5, rv); check("w1c_after_race", rv, 32'h0);

    // Reset in the middle of a debounce count
    wr(3'd6, 16'h0008);
    wr(3'd0, 16'h1234);
    wr(3'd1, 16'h0F0F);
    wr(3'd3, 16'hFFFF);
    pad_in = 16'h0006;
    tick(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_out", pad_out, 32'h0);
    check("mid_rst_oeb", pad_oeb, 32'hFFFF);
    check("mid_rst_irq", irq, 32'h0);
    check("mid_rst_rdata", bus.reg_rdata, 32'h0);
    rd(3'd2, rv); check("mid_rst_din", rv, 32'h0);
    rd(3'd6, rv); check("mid_rst_dbc", rv, 32'h0);
    rd(3'd3, rv); check("mid_rst_en", rv, 32'h0);
    rd(3'd4, rv); check("mid_rst_edge", rv, 32'hFFFF);
    tick(3);
    rd(3'd2, rv); check("post_rst_din", rv, 32'h0006);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
